// File: rtl/mips_pipe_ctrl.sv
// rtl/mips_pipe_ctrl.sv - stall/flush/forwarding control for a parametrised MIPS pipeline
module mips_pipe_ctrl #(
    parameter int STAGES   = 5,
    parameter int BR_STAGE = 3,
    parameter int RA_W     = 5,
    parameter int CNT_W    = 32,
    parameter int FWD_W    = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [RA_W-1:0]   id_rs,
    input  logic [RA_W-1:0]   id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [RA_W-1:0]   id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              br_taken,
    output logic              pc_en,
    output logic              ifid_en,
    output logic [STAGES-1:0] stage_flush,
    output logic              ex_bubble,
    output logic [FWD_W-1:0]  fwd_a_sel,
    output logic [FWD_W-1:0]  fwd_b_sel,
    output logic              wb_valid,
    output logic [CNT_W-1:0]  cnt_retired,
    output logic [CNT_W-1:0]  cnt_stall,
    output logic [CNT_W-1:0]  cnt_flush
);

    // Per-stage tracking for EX (2) through WB (STAGES-1)
    logic [STAGES-1:2] v;
    logic [STAGES-1:2] rw;
    logic [STAGES-1:2] mr;
    logic [RA_W-1:0]   rd [2:STAGES-1];

    // Source operands of the instruction currently in EX
    logic [RA_W-1:0] ex_rs;
    logic [RA_W-1:0] ex_rt;
    logic            ex_use_rs;
    logic            ex_use_rt;

    logic hazard;
    logic br;
    logic stall;
    logic ex_load;

    // Load in EX whose result is needed by the instruction in ID
    always_comb begin
        hazard = id_valid & v[2] & mr[2] & (rd[2] != '0) &
                 ((id_use_rs & (id_rs == rd[2])) | (id_use_rt & (id_rt == rd[2])));
    end

    assign br        = br_taken & v[BR_STAGE];
    assign stall     = hazard & ~br;
    assign ex_load   = id_valid & ~stall & ~br;
    assign pc_en     = ~stall;
    assign ifid_en   = ~stall;
    assign ex_bubble = stall;
    assign wb_valid  = v[STAGES-1];

    // A taken branch kills everything younger than itself, IF/ID up to its own stage
    always_comb begin
        stage_flush = '0;
        for (int k = 1; k <= BR_STAGE; k++) begin
            stage_flush[k] = br;
        end
    end

    // Nearest older writer wins: scan from the oldest stage so the youngest overwrites
    always_comb begin
        fwd_a_sel = '0;
        fwd_b_sel = '0;
        for (int k = STAGES - 1; k >= 3; k--) begin
            if (v[k] && rw[k] && (rd[k] == ex_rs) && (ex_rs != '0) && ex_use_rs) begin
                fwd_a_sel = FWD_W'(k - 2);
            end
            if (v[k] && rw[k] && (rd[k] == ex_rt) && (ex_rt != '0) && ex_use_rt) begin
                fwd_b_sel = FWD_W'(k - 2);
            end
        end
    end

    // Stage state advance; bubbles and flushed slots carry all-zero fields
    always_ff @(posedge clk) begin
        if (reset) begin
            v         <= '0;
            rw        <= '0;
            mr        <= '0;
            ex_rs     <= '0;
            ex_rt     <= '0;
            ex_use_rs <= 1'b0;
            ex_use_rt <= 1'b0;
            for (int k = 2; k < STAGES; k++) begin
                rd[k] <= '0;
            end
        end else begin
            v[2]      <= ex_load;
            rw[2]     <= ex_load & id_regwrite;
            mr[2]     <= ex_load & id_memread;
            rd[2]     <= ex_load ? id_rd : '0;
            ex_rs     <= ex_load ? id_rs : '0;
            ex_rt     <= ex_load ? id_rt : '0;
            ex_use_rs <= ex_load & id_use_rs;
            ex_use_rt <= ex_load & id_use_rt;
            for (int k = 3; k < STAGES; k++) begin
                if (br && (k <= BR_STAGE)) begin
                    v[k]  <= 1'b0;
                    rw[k] <= 1'b0;
                    mr[k] <= 1'b0;
                    rd[k] <= '0;
                end else begin
                    v[k]  <= v[k-1];
                    rw[k] <= rw[k-1];
                    mr[k] <= mr[k-1];
                    rd[k] <= rd[k-1];
                end
            end
        end
    end

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_retired <= '0;
            cnt_stall   <= '0;
            cnt_flush   <= '0;
        end else begin
            if (wb_valid && (cnt_retired != '1)) cnt_retired <= cnt_retired + 1'b1;
            if (stall && (cnt_stall != '1))      cnt_stall   <= cnt_stall + 1'b1;
            if (br && (cnt_flush != '1))         cnt_flush   <= cnt_flush + 1'b1;
        end
    end

endmodule
